uart_rx: RTL

//   Serial receiver that pairs with the UART transmitter: recovers 8N1 frames
//   (1 start, DATA_BITS data LSB-first, 1 stop) from line i_bit using

---
 rtl/uart_rx.sv | 119 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, OVERSAMPLE clocks per bit, mid-bit sampling.
// Emits each good byte with a 1-cycle valid strobe; flags a low stop bit.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 baud_clk,
    input  logic                 rst_n,
    input  logic                 i_bit,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [1:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] sh_next;

    // Sync chain resets to 1 so an idle line does not look like an edge.
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_bit;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign sh_next = DATA_BITS'({rx_s, shreg} >> 1);
    assign busy    = (state != IDLE);

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                    end
                end
                START: begin
                    if (tick_cnt == T_MID) begin
                        state    <= rx_s ? IDLE : DATA;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == T_END) begin
                        shreg    <= sh_next;
                        tick_cnt <= '0;
                        if (bit_idx == B_LAST) begin
                            state   <= STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == T_END) begin
                        if (rx_s) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        state    <= IDLE;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

endmodule
